fs_nms: RTL and testbench

- Non-maximum suppression stage directly downstream of the FAST-9 score stage.
- Consumes the per-pixel score stream (score value plus corner-write strobe) in raster order.
- Buffers two image lines of scores and evaluates a 3x3 window around each interior pixel.
- Emits address and score only for corners that are local maxima, which thins clustered detections before descriptor/output logic.

---
 rtl/fs_nms_if.sv | 24 ++
 rtl/fs_nms.sv | 123 ++++++++++++
 tb/tb_fs_nms.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fs_nms_if.sv
// Score-stream / corner-output bundle between the FAST scorer, fs_nms and its consumer.
// The master side feeds pixel scores and observes surviving corners.
interface fs_nms_if #(
  parameter int ADDR_W = 15
);
  logic              scoreValid;
  logic [7:0]        scoreValue;
  logic              wren;
  logic              cornerValid;
  logic [ADDR_W-1:0] cornerAddr;
  logic [7:0]        cornerScore;
  logic              frameDone;
  logic              busy;

  modport master (
    output scoreValid, scoreValue, wren,
    input  cornerValid, cornerAddr, cornerScore, frameDone, busy
  );

  modport slave (
    input  scoreValid, scoreValue, wren,
    output cornerValid, cornerAddr, cornerScore, frameDone, busy
  );
endinterface

// File: rtl/fs_nms.sv
// 3x3 non-maximum suppression over a raster score stream, using two line buffers.
// Only local maxima with a raster-order tie-break are emitted, one cycle after the closing pixel.
module fs_nms #(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int ADDR_W = 15
) (
  input  logic      clock,
  input  logic      nReset,
  fs_nms_if.slave   nms
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [ADDR_W-1:0] CENTRE_OFS = ADDR_W'(IMG_W + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [ADDR_W-1:0] row_base;

  logic [7:0] lb1 [IMG_W];
  logic [7:0] lb2 [IMG_W];
  logic [7:0] top_a_p0, top_b_p0, mid_a_p0, mid_b_p0, bot_a_p0, bot_b_p0;

  logic              accept;
  logic [7:0]        s_in;
  logic [7:0]        top_n, mid_n;
  logic              last_col, last_row, eval_ok, peak;
  logic [ADDR_W-1:0] centre_addr;

  // Earlier raster neighbours must be strictly below the centre, later ones may tie.
  function automatic logic is_peak(
    input logic [7:0] c,
    input logic [7:0] ta, input logic [7:0] tb, input logic [7:0] tn,
    input logic [7:0] ma, input logic [7:0] mn,
    input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] bn
  );
    return (c != 8'd0) &&
           (ta < c) && (tb < c) && (tn < c) && (ma < c) &&
           (mn <= c) && (ba <= c) && (bb <= c) && (bn <= c);
  endfunction

  assign accept      = nms.scoreValid && (state != DONE);
  assign s_in        = nms.wren ? nms.scoreValue : 8'd0;
  assign top_n       = lb2[col];
  assign mid_n       = lb1[col];
  assign last_col    = (col == CW'(IMG_W - 1));
  assign last_row    = (row == RW'(IMG_H - 1));
  assign eval_ok     = (row >= RW'(2)) && (col >= CW'(2));
  assign peak        = is_peak(mid_b_p0, top_a_p0, top_b_p0, top_n, mid_a_p0, mid_n,
                               bot_a_p0, bot_b_p0, s_in);
  assign centre_addr = row_base + ADDR_W'(col) - CENTRE_OFS;

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state           <= IDLE;
      col             <= '0;
      row             <= '0;
      row_base        <= '0;
      nms.cornerValid <= 1'b0;
      nms.cornerAddr  <= '0;
      nms.cornerScore <= 8'd0;
      nms.frameDone   <= 1'b0;
      nms.busy        <= 1'b0;
    end else begin
      nms.cornerValid <= 1'b0;
      nms.frameDone   <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          state    <= RUN;
          nms.busy <= 1'b1;
        end
        RUN: if (accept && last_col && last_row) begin
          state         <= DONE;
          nms.busy      <= 1'b0;
          nms.frameDone <= 1'b1;
        end
        default: state <= IDLE;
      endcase
      if (accept) begin
        if (last_col) begin
          col <= '0;
          if (last_row) begin
            row      <= '0;
            row_base <= '0;
          end else begin
            row      <= row + RW'(1);
            row_base <= row_base + ADDR_W'(IMG_W);
          end
        end else begin
          col <= col + CW'(1);
        end
        // Output stage: register the evaluated centre
        if (eval_ok && peak) begin
          nms.cornerValid <= 1'b1;
          nms.cornerAddr  <= centre_addr;
          nms.cornerScore <= mid_b_p0;
        end
      end
      if (state == DONE) begin
        col      <= '0;
        row      <= '0;
        row_base <= '0;
      end
    end
  end

  // Window stage: line buffers and the two retained window columns shift per accepted pixel
  always_ff @(posedge clock) begin
    if (accept) begin
      lb2[col] <= mid_n;
      lb1[col] <= s_in;
      top_a_p0 <= top_b_p0;
      top_b_p0 <= top_n;
      mid_a_p0 <= mid_b_p0;
      mid_b_p0 <= mid_n;
      bot_a_p0 <= bot_b_p0;
      bot_b_p0 <= s_in;
    end
  end
endmodule

// File: tb/tb_fs_nms.sv
// Directed bench for fs_nms on an 8x6 image: a raster-order NMS model checks every cycle,
// and literal expectations per scenario pin the model.
module tb_fs_nms;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int N  = W * H;
  localparam int AW = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fs_nms_if #(.ADDR_W(AW)) bus ();

  fs_nms #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clock (clk),
    .nReset(rst_n),
    .nms   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int cur_val [N];
  bit cur_wr  [N];

  int obs_addr [$];
  int obs_score[$];
  int obs_k    [$];
  int fd_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff(input int i);
    return cur_wr[i] ? cur_val[i] : 0;
  endfunction

  // Local maximum with raster-order tie-break, straight from the image
  function automatic bit model_peak(input int cr, input int cc);
    int s;
    int nb;
    s = eff(cr * W + cc);
    if (s == 0) return 1'b0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (dr == 0 && dc == 0) continue;
        nb = eff((cr + dr) * W + cc + dc);
        if (dr < 0 || (dr == 0 && dc < 0)) begin
          if (!(nb < s)) return 1'b0;
        end else begin
          if (!(nb <= s)) return 1'b0;
        end
      end
    end
    return 1'b1;
  endfunction

  // Compare process
  initial begin
    int  k;
    bit  in_frame;
    bit  done_pending;
    int  last_addr;
    int  last_score;
    int  r, c;
    bit  exp_v;
    k = 0; in_frame = 0; done_pending = 0; last_addr = 0; last_score = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        k = 0; in_frame = 0; done_pending = 0; last_addr = 0; last_score = 0;
        check("rst_cornerValid", bus.cornerValid, 0);
        check("rst_cornerAddr",  bus.cornerAddr, 0);
        check("rst_cornerScore", bus.cornerScore, 0);
        check("rst_frameDone",   bus.frameDone, 0);
        check("rst_busy",        bus.busy, 0);
      end else if (bus.scoreValid && !done_pending) begin
        r = k / W;
        c = k % W;
        exp_v = (r >= 2) && (c >= 2) && model_peak(r - 1, c - 1);
        check("cornerValid", bus.cornerValid, exp_v);
        if (exp_v) begin
          last_addr  = (r - 1) * W + (c - 1);
          last_score = eff(last_addr);
        end
        check("cornerAddr",  bus.cornerAddr, last_addr);
        check("cornerScore", bus.cornerScore, last_score);
        check("frameDone",   bus.frameDone, (k == N - 1));
        if (bus.cornerValid) begin
          obs_addr.push_back(int'(bus.cornerAddr));
          obs_score.push_back(int'(bus.cornerScore));
          obs_k.push_back(k);
        end
        if (bus.frameDone) fd_cnt++;
        k++;
        if (k == N) begin
          k = 0; in_frame = 0; done_pending = 1;
        end else begin
          in_frame = 1;
        end
        check("busy", bus.busy, in_frame);
      end else begin
        done_pending = 0;
        check("idle_cornerValid", bus.cornerValid, 0);
        check("idle_frameDone",   bus.frameDone, 0);
        check("idle_cornerAddr",  bus.cornerAddr, last_addr);
        check("busy", bus.busy, in_frame);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.scoreValid = 1'b0;
      bus.wren       = 1'b0;
      bus.scoreValue = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic pix(input int k, input bit gaps);
    if (gaps) idle($urandom_range(0, 2));
    @(negedge clk);
    bus.scoreValid = 1'b1;
    bus.scoreValue = 8'(cur_val[k]);
    bus.wren       = cur_wr[k];
  endtask

  task automatic clear_img();
    for (int i = 0; i < N; i++) begin
      cur_val[i] = $urandom_range(0, 255);
      cur_wr[i]  = 1'b0;
    end
  endtask

  task automatic set_px(input int r, input int c, input int v);
    cur_val[r * W + c] = v;
    cur_wr[r * W + c]  = 1'b1;
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_score.delete();
    obs_k.delete();
    fd_cnt = 0;
  endtask

  task automatic run_frame(input bit gaps);
    clear_obs();
    for (int k = 0; k < N; k++) pix(k, gaps);
    idle(3);
  endtask

  task automatic expect_one(input string name, input int addr, input int score, input int at_k);
    check({name, "_count"}, obs_addr.size(), 1);
    if (obs_addr.size() >= 1) begin
      check({name, "_addr"},  obs_addr[0], addr);
      check({name, "_score"}, obs_score[0], score);
      check({name, "_pixel"}, obs_k[0], at_k);
    end
    check({name, "_frameDone"}, fd_cnt, 1);
  endtask

  task automatic expect_none(input string name);
    check({name, "_count"}, obs_addr.size(), 0);
    check({name, "_frameDone"}, fd_cnt, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.scoreValid = 1'b0;
    bus.scoreValue = 8'd0;
    bus.wren       = 1'b0;
    clear_img();
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    clear_img(); set_px(2, 3, 40);
    run_frame(1'b0);
    expect_one("isolated", 19, 40, 28);

    clear_img(); set_px(2, 2, 50); set_px(2, 3, 50);
    run_frame(1'b0);
    expect_one("tie", 18, 50, 27);

    clear_img(); set_px(2, 2, 50); set_px(2, 3, 60);
    run_frame(1'b0);
    expect_one("tie_var", 19, 60, 28);

    clear_img();
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        set_px(3 + dr, 3 + dc, (dr == 0 && dc == 0) ? 90 : 80);
    run_frame(1'b0);
    expect_one("cluster", 27, 90, 36);

    clear_img(); cur_val[3 * W + 3] = 200; cur_wr[3 * W + 3] = 1'b0;
    run_frame(1'b0);
    expect_none("wren0");

    clear_img(); set_px(0, 4, 99); set_px(5, 2, 99); set_px(3, 0, 99); set_px(3, 7, 99);
    run_frame(1'b0);
    expect_none("border");

    clear_img(); set_px(2, 3, 40);
    run_frame(1'b1);
    expect_one("gapped", 19, 40, 28);

    // Partial frame with a corner at (1,1), then reset while pixel 20 is presented
    clear_img(); set_px(1, 1, 70);
    clear_obs();
    for (int k = 0; k < 20; k++) pix(k, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    bus.scoreValid = 1'b1;
    bus.scoreValue = 8'(cur_val[20]);
    bus.wren       = cur_wr[20];
    check("partial_count", obs_addr.size(), 1);
    if (obs_addr.size() >= 1) begin
      check("partial_addr", obs_addr[0], 9);
      check("partial_pixel", obs_k[0], 18);
    end
    clear_obs();
    idle(3);
    check("reset_pulses", obs_addr.size() + fd_cnt, 0);
    rst_n = 1'b1;
    idle(1);
    clear_img(); set_px(2, 3, 40);
    run_frame(1'b0);
    expect_one("after_reset", 19, 40, 28);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
